// File: rtl/bcd_updown_counter_pkg.sv
// Shared constants and helpers for the multi-digit BCD up/down counter.
// All digit arithmetic is done in 4-bit BCD with values restricted to 0..9.
package bcd_updown_counter_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_MIN = 4'd0;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Non-BCD codes (A..F) are clamped to 9 so q never holds an illegal digit.
  function automatic bcd_digit_t bcd_clamp(input bcd_digit_t val);
    return (val > BCD_MAX) ? BCD_MAX : val;
  endfunction

  function automatic logic bcd_is_bad(input bcd_digit_t val);
    return (val > BCD_MAX);
  endfunction

endpackage

// File: rtl/bcd_updown_counter_bcd_digit.sv
// One BCD digit of the cascaded counter: clear, clamped load, and a single
// increment/decrement step when its carry/borrow-in enable is high.
module bcd_digit
  import bcd_updown_counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               ld,
  input  logic [DIGIT_W-1:0] ld_val,
  input  logic               cin_en,
  input  logic               up,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_max,
  output logic               at_min
);

  bcd_digit_t digit_q;
  bcd_digit_t digit_d;

  assign at_max = (digit_q == BCD_MAX);
  assign at_min = (digit_q == BCD_MIN);
  assign digit  = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (clr) begin
      digit_d = BCD_MIN;
    end else if (ld) begin
      digit_d = bcd_clamp(ld_val);
    end else if (cin_en) begin
      if (up) begin
        digit_d = at_max ? BCD_MIN : digit_q + 4'd1;
      end else begin
        digit_d = at_min ? BCD_MAX : digit_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digit_q <= BCD_MIN;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_updown_counter.sv
// Parametrised multi-digit BCD up/down counter with wrap or saturate at the
// terminal count, sticky overflow and a one-cycle bad-load indication.
module bcd_updown_counter
  import bcd_updown_counter_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int SATURATE = 0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr,
  input  logic                      load,
  input  logic [DIGIT_W*DIGITS-1:0] d,
  input  logic                      en,
  input  logic                      up,
  output logic [DIGIT_W*DIGITS-1:0] q,
  output logic                      tc,
  output logic                      ovf,
  output logic                      load_err
);

  localparam logic SAT_EN = (SATURATE != 0);

  logic [DIGITS:0]   term_chain;
  logic [DIGITS-1:0] cin_en;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_min;
  logic [DIGITS-1:0] ld_bad;
  logic              sat_hold;
  logic              any_bad;

  logic ovf_q;
  logic ovf_d;
  logic load_err_q;
  logic load_err_d;

  // term_chain[i] is high when counting is enabled and every digit below i
  // sits at its terminal value for the current direction.
  assign term_chain[0] = en;

  // In saturate mode the whole chain is frozen once the terminal state is hit.
  assign sat_hold = SAT_EN & term_chain[DIGITS];

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign term_chain[gi+1] = term_chain[gi] & (up ? at_max[gi] : at_min[gi]);
      assign cin_en[gi]       = term_chain[gi] & ~sat_hold;
      assign ld_bad[gi]       = bcd_is_bad(d[gi*DIGIT_W +: DIGIT_W]);

      bcd_digit u_digit (
        .clk    (clk),
        .rst    (rst),
        .clr    (clr),
        .ld     (load),
        .ld_val (d[gi*DIGIT_W +: DIGIT_W]),
        .cin_en (cin_en[gi]),
        .up     (up),
        .digit  (q[gi*DIGIT_W +: DIGIT_W]),
        .at_max (at_max[gi]),
        .at_min (at_min[gi])
      );
    end
  endgenerate

  assign any_bad = |ld_bad;
  assign tc      = term_chain[DIGITS] & ~clr & ~load;

  always_comb begin
    ovf_d      = ovf_q;
    load_err_d = 1'b0;
    if (clr) begin
      ovf_d = 1'b0;
    end else if (load) begin
      load_err_d = any_bad;
    end else if (tc) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ovf_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      ovf_q      <= ovf_d;
      load_err_q <= load_err_d;
    end
  end

  assign ovf      = ovf_q;
  assign load_err = load_err_q;

endmodule
